// File: rtl/counter_pkg.sv
// Shared constants and helpers for the programmable counter family.
`default_nettype none

package counter_pkg;

  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

  localparam logic CNT_DIR_UP = 1'b1;
  localparam logic CNT_DIR_DN = 1'b0;

  // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_prescale.sv
// Enable prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
`default_nettype none

module counter_prescale
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  // At least one bit so PRESCALE=1 degenerates to tick = en.
  localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sync_clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/counter_prog.sv
// Programmable up/down counter with modulus, wrap/saturate, load/clear,
// prescaler, terminal-count pulse and compare-match flag.
`default_nettype none

module counter_prog
  import counter_pkg::*;
#(
  parameter int               WIDTH    = 12,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               SATURATE = CNT_MODE_WRAP,
  parameter int               PRESCALE = 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             d_en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] d_out,
  output logic             tc,
  output logic             cmp_match
);

  logic             tick;
  logic [WIDTH-1:0] d_next;
  logic             tc_next;

  // clr and load both discard any partial prescale count.
  counter_prescale #(
    .PRESCALE (PRESCALE)
  ) u_prescale (
    .clock    (clock),
    .rst_n    (rst_n),
    .en       (d_en),
    .sync_clr (clr | load),
    .tick     (tick)
  );

  always_comb begin
    d_next  = d_out;
    tc_next = 1'b0;
    if (clr) begin
      d_next = '0;
    end else if (load) begin
      d_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end else if (tick) begin
      if (up_dn == CNT_DIR_UP) begin
        if (d_out == MAX_VAL) begin
          tc_next = 1'b1;
          d_next  = (SATURATE == CNT_MODE_SAT) ? MAX_VAL : '0;
        end else begin
          d_next = d_out + 1'b1;
        end
      end else begin
        if (d_out == '0) begin
          tc_next = 1'b1;
          d_next  = (SATURATE == CNT_MODE_SAT) ? '0 : MAX_VAL;
        end else begin
          d_next = d_out - 1'b1;
        end
      end
    end
  end

  // d_next never exceeds MAX_VAL, so an out-of-range cmp_val cannot match.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      d_out     <= RST_VAL;
      tc        <= 1'b0;
      cmp_match <= 1'b0;
    end else begin
      d_out     <= d_next;
      tc        <= tc_next;
      cmp_match <= (d_next == cmp_val);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_counter_prog.sv
// Scoreboard bench for counter_prog across four parameter configurations.
`timescale 1ns/1ps
`default_nettype none

module tb_counter_prog;

  logic        clock = 1'b0;
  logic        rst_n, d_en, up_dn, clr, load;
  logic [11:0] load_val, cmp_val;
  logic [11:0] d_a;
  logic [3:0]  d_b, d_c, d_d;
  logic [3:0]  tc_v, cm_v;

  always #5 clock = ~clock;

  // a: 12-bit wrap, RST_VAL=5   b: mod-10 wrap   c: mod-10 saturate   d: mod-10 wrap, prescale 4
  counter_prog #(.WIDTH(12), .RST_VAL(12'h005)) dut_a (
    .clock(clock), .rst_n(rst_n), .d_en(d_en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .cmp_val(cmp_val), .d_out(d_a), .tc(tc_v[0]), .cmp_match(cm_v[0]));
  counter_prog #(.WIDTH(4), .MAX_VAL(4'd9)) dut_b (
    .clock(clock), .rst_n(rst_n), .d_en(d_en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .cmp_val(cmp_val[3:0]), .d_out(d_b), .tc(tc_v[1]), .cmp_match(cm_v[1]));
  counter_prog #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1)) dut_c (
    .clock(clock), .rst_n(rst_n), .d_en(d_en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .cmp_val(cmp_val[3:0]), .d_out(d_c), .tc(tc_v[2]), .cmp_match(cm_v[2]));
  counter_prog #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(4)) dut_d (
    .clock(clock), .rst_n(rst_n), .d_en(d_en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val[3:0]), .cmp_val(cmp_val[3:0]), .d_out(d_d), .tc(tc_v[3]), .cmp_match(cm_v[3]));

  typedef struct {
    int idx;
    int d;
    bit tc;
    bit cm;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int mx[4]  = '{4095, 9, 9, 9};
  int msk[4] = '{4095, 15, 15, 15};
  int sat[4] = '{0, 0, 1, 0};
  int pre[4] = '{1, 1, 1, 4};
  int rv[4]  = '{5, 0, 0, 0};
  int md[4], mp[4];
  bit mtc[4], mcm[4];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int obs_d(input int i);
    case (i)
      0:       return int'(d_a);
      1:       return int'(d_b);
      2:       return int'(d_c);
      default: return int'(d_d);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      md[i] = rv[i]; mp[i] = 0; mtc[i] = 0; mcm[i] = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      int lv, cv;
      bit tk;
      lv = int'(load_val) & msk[i];
      cv = int'(cmp_val) & msk[i];
      mtc[i] = 0;
      if (clr) begin
        md[i] = 0; mp[i] = 0;
      end else if (load) begin
        md[i] = (lv > mx[i]) ? mx[i] : lv; mp[i] = 0;
      end else if (d_en) begin
        tk    = (mp[i] == pre[i] - 1);
        mp[i] = tk ? 0 : mp[i] + 1;
        if (tk) begin
          if (up_dn) begin
            if (md[i] == mx[i]) begin mtc[i] = 1; md[i] = sat[i] ? mx[i] : 0; end
            else md[i] = md[i] + 1;
          end else begin
            if (md[i] == 0) begin mtc[i] = 1; md[i] = sat[i] ? 0 : mx[i]; end
            else md[i] = md[i] - 1;
          end
        end
      end
      mcm[i] = (md[i] == cv);
      e.idx = i; e.d = md[i]; e.tc = mtc[i]; e.cm = mcm[i];
      q.push_back(e);
    end
    @(posedge clock);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check_val($sformatf("d_out[%0d]", e.idx), obs_d(e.idx), e.d);
      check_val($sformatf("tc[%0d]", e.idx), tc_v[e.idx], e.tc);
      check_val($sformatf("cmp_match[%0d]", e.idx), cm_v[e.idx], e.cm);
    end
    @(negedge clock);
  endtask

  task automatic drive(input bit en, input bit up, input bit c, input bit l, input int lv);
    d_en = en; up_dn = up; clr = c; load = l; load_val = 12'(lv);
  endtask

  initial begin
    rst_n = 1'b0; d_en = 0; up_dn = 1; clr = 0; load = 0; load_val = '0; cmp_val = 12'd5;
    model_reset();
    repeat (3) @(negedge clock);
    check_val("rst_a", d_a, 12'h005);
    check_val("rst_b", d_b, 4'd0);
    check_val("rst_tc", tc_v, 4'b0000);
    check_val("rst_cm", cm_v, 4'b0000);
    rst_n = 1'b1;

    // Count dut_a from 5 up to 0x123, then assert reset between edges.
    drive(1, 1, 0, 0, 0);
    for (int n = 0; n < 400 && md[0] != 'h123; n++) cycle();
    check_val("a_reach", d_a, 12'h123);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_a", d_a, 12'h005);
    check_val("async_tc", tc_v, 4'b0000);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    cycle();
    check_val("a_resume", d_a, 12'h006);

    // Wrap at MAX_VAL=9.
    drive(0, 1, 1, 0, 0); cycle();
    drive(1, 1, 0, 0, 0);
    repeat (10) cycle();
    check_val("b_wrap", d_b, 4'd0);
    check_val("b_wrap_tc", tc_v[1], 1'b1);
    repeat (2) cycle();

    // Saturating count down from 2.
    drive(0, 1, 0, 1, 2); cycle();
    drive(1, 0, 0, 0, 0);
    repeat (3) cycle();
    check_val("c_sat", d_c, 4'd0);
    check_val("c_sat_tc1", tc_v[2], 1'b1);
    cycle();
    check_val("c_sat_tc2", tc_v[2], 1'b1);

    // Prescaler with an enable gap mid-window.
    drive(0, 1, 0, 1, 0); cycle();
    drive(1, 1, 0, 0, 0); repeat (2) cycle();
    drive(0, 1, 0, 0, 0); repeat (2) cycle();
    check_val("d_hold", d_d, 4'd0);
    drive(1, 1, 0, 0, 0); cycle();
    check_val("d_prestep", d_d, 4'd0);
    cycle();
    check_val("d_step", d_d, 4'd1);
    repeat (6) cycle();

    // Priority and clamping.
    drive(1, 1, 1, 1, 7); cycle();
    check_val("clr_over_load", d_b, 4'd0);
    drive(0, 1, 0, 1, 15); cycle();
    check_val("clamp_b", d_b, 4'd9);
    check_val("noclamp_a", d_a, 12'd15);
    drive(0, 1, 0, 1, 0); cycle();
    drive(1, 1, 0, 0, 0); repeat (2) cycle();
    drive(1, 1, 0, 1, 3); cycle();
    drive(1, 1, 0, 0, 0); repeat (3) cycle();
    check_val("load_discard", d_d, 4'd3);
    cycle();
    check_val("load_step", d_d, 4'd4);

    // Compare value above MAX_VAL across a full wrap.
    cmp_val = 12'd12;
    drive(0, 1, 0, 1, 0); cycle();
    drive(1, 1, 0, 0, 0); repeat (12) cycle();

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      drive(($urandom % 4) != 0, $urandom % 2, ($urandom % 20) == 0, ($urandom % 10) == 0,
            int'($urandom % 4096));
      cmp_val = ($urandom % 4 == 0) ? 12'($urandom % 4096) : 12'($urandom % 16);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/counter_prog.md
Name: counter_prog

Overview:
- Parametrised successor to the fixed 12-bit enabled up-counter.
- Adds programmable modulus, up/down direction, wrap or saturate mode, synchronous load and clear, a prescaler, a terminal-count pulse and a compare-match flag.
- Used as the generic timer/counter primitive in the counter benchmark family. It is fully synchronous to one clock, with an asynchronous active-low reset.

Parameters:
- WIDTH, 12, counter width in bits (2..32).
- MAX_VAL, 2**WIDTH-1, terminal value. Count range is 0..MAX_VAL. Must be ≥1 and ≤2**WIDTH-1.
- RST_VAL, 0, value of d_out after reset. Must be ≤MAX_VAL.
- SATURATE, 0, boundary mode: 0 = wrap, 1 = hold at the boundary.
- PRESCALE, 1, enabled cycles per count step (1..256). 1 = step on every enabled cycle.

Ports:
- clock, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset. Assertion takes effect immediately; deassertion is synchronous to clock.
- d_en, in, 1, count enable; gates the prescaler and counting.
- up_dn, in, 1, direction: 1 = up, 0 = down.
- clr, in, 1, synchronous clear to 0 (highest priority).
- load, in, 1, synchronous load of load_val.
- load_val, in, WIDTH, load value.
- cmp_val, in, WIDTH, compare value.
- d_out, out, WIDTH, registered count.
- tc, out, 1, registered one-cycle terminal-count pulse.
- cmp_match, out, 1, registered flag, high while d_out == cmp_val.

Behaviour:
- **Reset (rst_n=0, asynchronous):**
  - d_out=RST_VAL, tc=0, cmp_match=0, prescaler=0.
  - Takes effect without a clock edge, including mid-count.
- **Priority each rising edge:** clr > load > count step > hold.
- **clr=1:**
  - d_out←0, prescaler←0, tc←0.
  - load and d_en are ignored that cycle.
- **load=1 (and clr=0):**
  - d_out←min(load_val, MAX_VAL), so values above MAX_VAL clamp to MAX_VAL.
  - prescaler←0, tc←0.
- **Prescaler tick:**
  - tick = d_en & (prescaler == PRESCALE-1).
  - When d_en=1 and there is no tick, prescaler increments. On a tick, prescaler←0.
  - When d_en=0, prescaler and d_out hold and tc←0.
  - With PRESCALE=1, tick = d_en.
- **Count step on tick, up (up_dn=1):**
  - d_out<MAX_VAL: d_out+1, tc←0.
  - d_out==MAX_VAL: d_out←0 if SATURATE=0, else hold MAX_VAL. tc←1 in both modes.
- **Count step on tick, down (up_dn=0):**
  - d_out>0: d_out−1, tc←0.
  - d_out==0: d_out←MAX_VAL if SATURATE=0, else hold 0. tc←1 in both modes.
- **tc timing:**
  - tc is high for exactly one cycle, after the edge that processed a boundary tick.
  - In saturate mode, tc re-pulses on every tick while the counter is held at the boundary.
  - Any cycle without a boundary tick drives tc←0.
- **Direction change:** up_dn may change on any cycle; it is sampled only on a tick. No glitch or extra step results.
- **cmp_match:** registered as (d_next == cmp_val), so it is aligned with d_out. A cmp_val above MAX_VAL never matches.
- **Latency:** d_out changes at the first edge where the tick, load or clr is sampled (one-cycle latency from the inputs).
- **Arithmetic:** unsigned modulo behaviour only at the MAX_VAL/0 boundary as defined above. No intermediate overflow beyond WIDTH bits.

Decomposition:
- **Package counter_pkg:**
  - Constants CNT_MODE_WRAP=0 and CNT_MODE_SAT=1.
  - Direction constants CNT_DIR_UP=1 and CNT_DIR_DN=0.
  - Function clog2, used for prescaler width.
- **Sub-module counter_prescale:**
  - Parameter PRESCALE.
  - Inputs clock, rst_n, en, sync_clr.
  - Output tick.
- The counter core, boundary logic, tc and cmp_match stay in counter_prog.

Test Plan:
1. Async reset: WIDTH=12, RST_VAL=0x005. Count to 0x123, pull rst_n low between edges → d_out=0x005 and tc=0 immediately. Release rst_n → counting resumes 0x006 on the next enabled edge.
2. Wrap up: WIDTH=4, MAX_VAL=9, up, d_en=1 → d_out 0,1,…,9,0,1. tc is high only in the cycle d_out shows 0 after 9.
3. Saturate down: SATURATE=1, load 2, up_dn=0 → d_out 2,1,0,0,0. tc is high in each cycle after a tick processed at 0 (two consecutive pulses).
4. Prescaler: PRESCALE=4, d_en=1 → d_out increments every 4 cycles. Drop d_en for 2 cycles mid-window → the step is delayed by exactly 2 cycles, and d_out and prescaler hold meanwhile.
5. Priority and clamping: MAX_VAL=9, clr=1 and load=1 with load_val=7 in the same cycle → d_out=0. load_val=15 alone → d_out=9. A load while d_en=1 discards the partial prescale count.
6. Compare: cmp_val=5, MAX_VAL=9, counting up → cmp_match is high exactly while d_out=5. With cmp_val=12, cmp_match stays 0 for a full wrap cycle.
